// File: rtl/matkey_if.sv
// Keypad matrix bundle: column strobe towards the keypad, row sense back, key events towards the lock controller.
interface matkey_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int CW = $clog2(ROWS * COLS);

    logic [ROWS-1:0] row;
    logic            repeat_en;
    logic [COLS-1:0] col;
    logic [CW-1:0]   key_code;
    logic            key_valid;
    logic            key_repeat;
    logic            key_held;
    logic            key_release;

    modport master (
        input  row, repeat_en,
        output col, key_code, key_valid, key_repeat, key_held, key_release
    );

    modport slave (
        output row, repeat_en,
        input  col, key_code, key_valid, key_repeat, key_held, key_release
    );
endinterface

// File: rtl/matkey_scanner.sv
// ROWS x COLS matrix keypad scanner: one-hot column strobe, per-frame key classification,
// frame-level debounce, press/release events and optional auto-repeat.
module matkey_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 25000,
    parameter int DB_FRAMES    = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic     clk,
    input  logic     rst,
    matkey_if.master kbd
);
    localparam int CW    = $clog2(ROWS * COLS);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int COL_W = $clog2(COLS);
    localparam int DB_W  = $clog2(DB_FRAMES + 1);
    localparam int RPT_W = $clog2(REPEAT_DELAY + 2);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    // Key counts only need to distinguish 0, 1 and "two or more".
    function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 3'd2) ? 2'd2 : s[1:0];
    endfunction

    function automatic logic db_done(input logic [DB_W-1:0] v);
        return (int'(v) + 1) >= DB_FRAMES;
    endfunction

    logic [ROWS-1:0]  row_p0, row_p1;
    logic [DIV_W-1:0] div_cnt;
    logic [COL_W-1:0] col_idx;
    logic [COLS-1:0]  col_q;
    logic [1:0]       acc_cnt, col_hits, frm_cnt;
    logic [CW-1:0]    acc_code, col_code, frm_code;
    logic             last_dwell, frame_end;

    state_t           state;
    logic [CW-1:0]    cand;
    logic [DB_W-1:0]  db_cnt;
    logic [RPT_W-1:0] rpt_cnt;
    logic [CW-1:0]    key_code_q;
    logic             key_valid_q, key_repeat_q, key_held_q, key_release_q;

    assign last_dwell = (div_cnt == DIV_LAST);
    assign frame_end  = last_dwell && (col_idx == COL_LAST);

    // Descending walk so the final hit is the lowest row of this column.
    always_comb begin
        col_hits = 2'd0;
        col_code = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (row_p1[r]) begin
                col_hits = sat_add2(col_hits, 2'd1);
                col_code = CW'(r * COLS + int'(col_idx));
            end
        end
    end

    always_comb begin
        frm_cnt  = sat_add2(acc_cnt, col_hits);
        frm_code = acc_code;
        if (col_hits != 2'd0 && (acc_cnt == 2'd0 || col_code < acc_code))
            frm_code = col_code;
    end

    // Stage p0/p1: row synchroniser, then column dwell and frame accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_p0   <= '0;
            row_p1   <= '0;
            div_cnt  <= '0;
            col_idx  <= '0;
            col_q    <= COLS'(1);
            acc_cnt  <= 2'd0;
            acc_code <= '0;
        end else begin
            row_p0 <= kbd.row;
            row_p1 <= row_p0;
            if (last_dwell) begin
                div_cnt <= '0;
                col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
                col_q   <= {col_q[COLS-2:0], col_q[COLS-1]};
                if (frame_end) begin
                    acc_cnt  <= 2'd0;
                    acc_code <= '0;
                end else begin
                    acc_cnt  <= frm_cnt;
                    acc_code <= frm_code;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Stage p2: per-frame debounce / hold / repeat state machine with registered events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cand          <= '0;
            db_cnt        <= '0;
            rpt_cnt       <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_repeat_q  <= 1'b0;
            key_held_q    <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            key_valid_q   <= 1'b0;
            key_repeat_q  <= 1'b0;
            key_release_q <= 1'b0;
            if (frame_end) begin
                case (state)
                    IDLE: begin
                        if (frm_cnt == 2'd1) begin
                            cand <= frm_code;
                            if (DB_FRAMES == 1) begin
                                key_code_q  <= frm_code;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                rpt_cnt     <= '0;
                                db_cnt      <= '0;
                                state       <= PRESSED;
                            end else begin
                                db_cnt <= DB_W'(1);
                                state  <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (frm_cnt == 2'd1 && frm_code == cand) begin
                            if (db_done(db_cnt)) begin
                                key_code_q  <= cand;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                rpt_cnt     <= '0;
                                db_cnt      <= '0;
                                state       <= PRESSED;
                            end else begin
                                db_cnt <= db_cnt + 1'b1;
                            end
                        end else begin
                            db_cnt <= '0;
                            state  <= IDLE;
                        end
                    end
                    PRESSED: begin
                        if (frm_cnt == 2'd0) begin
                            if (DB_FRAMES == 1) begin
                                key_release_q <= 1'b1;
                                key_held_q    <= 1'b0;
                                state         <= IDLE;
                            end else begin
                                db_cnt <= DB_W'(1);
                                state  <= RELEASE;
                            end
                        end else if (frm_cnt == 2'd1 && frm_code == key_code_q) begin
                            if (!kbd.repeat_en) begin
                                rpt_cnt <= '0;
                            end else if ((int'(rpt_cnt) + 1) >= REPEAT_DELAY) begin
                                key_valid_q  <= 1'b1;
                                key_repeat_q <= 1'b1;
                                rpt_cnt      <= RPT_RELOAD;
                            end else begin
                                rpt_cnt <= rpt_cnt + 1'b1;
                            end
                        end
                    end
                    RELEASE: begin
                        if (frm_cnt == 2'd0) begin
                            if (db_done(db_cnt)) begin
                                key_release_q <= 1'b1;
                                key_held_q    <= 1'b0;
                                db_cnt        <= '0;
                                state         <= IDLE;
                            end else begin
                                db_cnt <= db_cnt + 1'b1;
                            end
                        end else begin
                            db_cnt <= '0;
                            state  <= PRESSED;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign kbd.col         = col_q;
    assign kbd.key_code    = key_code_q;
    assign kbd.key_valid   = key_valid_q;
    assign kbd.key_repeat  = key_repeat_q;
    assign kbd.key_held    = key_held_q;
    assign kbd.key_release = key_release_q;
endmodule

// File: doc/matkey_scanner.md
Name: matkey_scanner

Overview:
- Parametrised successor to the 4x4 keypad scanner.
- Drives a one-hot column strobe across a ROWS x COLS matrix and samples rows through a synchroniser.
- Classifies each full scan frame as no key, one key or several keys, then debounces over frames.
- Emits a one-cycle key event with a raw linear key code, plus release detection and optional auto-repeat. Digit/function mapping is done downstream by the lock controller.

Parameters:
- ROWS, 4, number of row inputs (>=1).
- COLS, 4, number of column outputs (>=2).
- SCAN_DIV, 25000, clk cycles each column is driven (>=4).
- DB_FRAMES, 20, consecutive identical frames needed to accept a press or a release (>=1).
- REPEAT_DELAY, 500, frames from accepted press to first repeat event.
- REPEAT_RATE, 100, frames between subsequent repeat events.
- CW, derived, $clog2(ROWS*COLS), key code width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- row  in  ROWS  row sense lines, active-high, asynchronous to clk.
- repeat_en  in  1  enables auto-repeat while a key is held.
- col  out  COLS  one-hot column drive, active-high.
- key_code  out  CW  code of the last accepted key = r*COLS + c (r = row index, c = column index).
- key_valid  out  1  one-cycle pulse per accepted press or repeat.
- key_repeat  out  1  qualifies key_valid: 1 = repeat event, 0 = initial press.
- key_held  out  1  high from accepted press until accepted release.
- key_release  out  1  one-cycle pulse on accepted release.

Behaviour:
- **Reset (async, immediate):**
  - col = 1 (column 0), dwell counter 0, frame accumulators cleared, FSM = IDLE.
  - key_code = 0; key_valid, key_repeat, key_held, key_release = 0; synchroniser flops = 0.
- **Scan:**
  - row passes through a 2-flop synchroniser.
  - Dwell counter counts 0..SCAN_DIV-1 per column.
  - On the last dwell cycle, the synchronised row is sampled for the current column; col then rotates left on the next cycle and wraps from bit COLS-1 to bit 0.
  - Frame end = sample of column COLS-1.
- **Frame classification:**
  - Per frame, count the asserted (row, col) bits and latch the code of the lowest-index asserted key.
  - At frame end, classify: NONE (0 keys), SINGLE(code) (1 key) or MULTI (>=2 keys).
  - Accumulators clear for the next frame.
- **FSM, evaluated once per frame end:**
  - **IDLE:**
    - SINGLE -> cand = code, cnt = 1, go DEBOUNCE.
    - NONE or MULTI -> stay.
    - DB_FRAMES = 1: SINGLE accepts the press immediately (event as below) and goes to PRESSED.
  - **DEBOUNCE:**
    - SINGLE equal to cand -> cnt++.
    - When cnt reaches DB_FRAMES: key_code = cand, key_valid = 1, key_repeat = 0, key_held = 1, repeat counter = 0, go PRESSED.
    - SINGLE with a different code, NONE or MULTI -> IDLE, cnt = 0.
  - **PRESSED:**
    - SINGLE equal to key_code -> repeat counter++.
    - If repeat_en, a repeat event fires when the counter reaches REPEAT_DELAY, then every REPEAT_RATE frames after that. A repeat event is key_valid = 1 with key_repeat = 1 and key_code unchanged.
    - repeat_en low -> counter held at 0.
    - MULTI or a different SINGLE -> stay PRESSED, no events, repeat counter held. No new key is accepted until full release (anti-ghosting rule).
    - NONE -> rcnt = 1, go RELEASE.
  - **RELEASE:**
    - NONE -> rcnt++. At DB_FRAMES: key_release = 1, key_held = 0, go IDLE.
    - Any key seen -> back to PRESSED, rcnt = 0; repeat counter keeps its value (treated as release bounce).
- **Timing:** outputs are registered. key_valid and key_release assert on the clk cycle after the frame-end sample and last exactly 1 cycle. key_repeat equals 0 whenever key_valid is 0.
- **Latency:** from a stable press to key_valid is at most (DB_FRAMES+1) frames plus 3 cycles, where frame = COLS*SCAN_DIV cycles.
- **Counters:** frame counters saturate and never wrap to a spurious event. The repeat counter reloads to REPEAT_DELAY-REPEAT_RATE after each repeat event.
- **Reset mid-press:** outputs clear immediately and no release pulse is emitted. The scan restarts at column 0.

Test Plan:
- Bench parameters: SCAN_DIV = 8, DB_FRAMES = 3, REPEAT_DELAY = 4, REPEAT_RATE = 2, ROWS = COLS = 4 (frame = 32 cycles).
- Reset then idle: col = 0001, then 0010 at cycle 8, 0100 at 16, 1000 at 24, 0001 at 32. No events; all outputs 0.
- Press row1 while col bit 2 is driven, steady: exactly one key_valid pulse with key_code = 6 and key_repeat = 0 after the 3rd qualifying frame; key_held = 1. Release: key_release pulses after 3 NONE frames; key_held = 0.
- Bounce: key 6 for 2 frames then NONE -> no key_valid. Accepted key 6 with 1 NONE frame then pressed again -> no key_release and no second valid.
- Multi-key: rows 0 and 2 asserted on col 0 together (codes 0, 8) -> no key_valid. Hold key 6 accepted, then add key 9 -> no new event; release both -> one key_release.
- Auto-repeat, repeat_en = 1, hold key 5: press event at frame 3, repeat events (key_repeat = 1, code 5) at frames 7, 9, 11, ... With repeat_en = 0 -> the press event only.
- Assert rst during PRESSED: col = 0001 and key_held = 0 in the same cycle, no key_release. After rst drops, the held key is re-accepted after 3 frames.
